// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 RGB LED matrix driver with 4-bit PWM per channel.
// A shadow copy of the frame is taken once per scan so the image never tears.
module led_matrix_scanner #(
    parameter int TICK_DIV    = 100,
    parameter int BLANK_TICKS = 1
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [3:0] reds   [63:0],
    input  logic [3:0] greens [63:0],
    input  logic [3:0] blues  [63:0],
    output logic [7:0] row_sel,
    output logic [7:0] col_r,
    output logic [7:0] col_g,
    output logic [7:0] col_b,
    output logic       frame_sync
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic [BW-1:0] r_bcnt;
    logic [BW-1:0] w_bcnt_nxt;
    logic [3:0]    r_pwm;
    logic [3:0]    w_pwm_nxt;
    logic [2:0]    r_row;
    logic [2:0]    w_row_nxt;
    logic          w_tick;
    logic          w_load;

    logic [3:0]    r_red [63:0];
    logic [3:0]    r_grn [63:0];
    logic [3:0]    r_blu [63:0];

    logic [7:0]    w_row_sel;
    logic [7:0]    w_col_r;
    logic [7:0]    w_col_g;
    logic [7:0]    w_col_b;

    assign w_tick = (r_cnt == TICK_LAST);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? '0 : r_cnt + TW'(1);
        w_bcnt_nxt  = r_bcnt;
        w_pwm_nxt   = r_pwm;
        w_row_nxt   = r_row;
        w_load      = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_load      = 1'b1;
                w_row_nxt   = '0;
                w_bcnt_nxt  = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_BLANK;
            end
            S_BLANK: begin
                if (w_tick) begin
                    if (r_bcnt == BLANK_LAST) begin
                        w_bcnt_nxt  = '0;
                        w_pwm_nxt   = '0;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_bcnt_nxt = r_bcnt + BW'(1);
                    end
                end
            end
            S_DRIVE: begin
                if (w_tick) begin
                    if (r_pwm == 4'hf) begin
                        if (r_row == 3'd7) begin
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_row_nxt   = r_row + 3'd1;
                            w_bcnt_nxt  = '0;
                            w_state_nxt = S_BLANK;
                        end
                    end else begin
                        w_pwm_nxt = r_pwm + 4'd1;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_cnt  <= '0;
            r_bcnt <= '0;
            r_pwm  <= '0;
            r_row  <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bcnt <= w_bcnt_nxt;
            r_pwm  <= w_pwm_nxt;
            r_row  <= w_row_nxt;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 64; i++) begin
                r_red[i] <= '0;
                r_grn[i] <= '0;
                r_blu[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < 64; i++) begin
                r_red[i] <= reds[i];
                r_grn[i] <= greens[i];
                r_blu[i] <= blues[i];
            end
        end
    end

    // Columns are lit only while a row is driven; pwm counts 0..15 per row.
    always_comb begin
        w_row_sel = '0;
        w_col_r   = '0;
        w_col_g   = '0;
        w_col_b   = '0;
        if (r_state == S_DRIVE) begin
            w_row_sel = 8'b1 << r_row;
            for (int c = 0; c < 8; c++) begin
                w_col_r[c] = r_red[{r_row, 3'(c)}] > r_pwm;
                w_col_g[c] = r_grn[{r_row, 3'(c)}] > r_pwm;
                w_col_b[c] = r_blu[{r_row, 3'(c)}] > r_pwm;
            end
        end
    end

    assign row_sel = w_row_sel;
    assign col_r   = w_col_r;
    assign col_g   = w_col_g;
    assign col_b   = w_col_b;

    // Reset parks the FSM in LOAD; keep the strobe quiet until reset lets go.
    assign frame_sync = (r_state == S_LOAD) & CPU_RESETN;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a frame-arithmetic reference model
// predicts every output cycle; a negedge monitor pops and compares.
module tb_led_matrix_scanner;

    localparam int TD     = 2;
    localparam int BT     = 1;
    localparam int ROWLEN = (BT + 16) * TD;
    localparam int PERIOD = 1 + 8 * ROWLEN;

    logic       CLK100MHZ  = 1'b0;
    logic       CPU_RESETN = 1'b0;
    logic [3:0] reds   [63:0];
    logic [3:0] greens [63:0];
    logic [3:0] blues  [63:0];
    logic [7:0] row_sel;
    logic [7:0] col_r;
    logic [7:0] col_g;
    logic [7:0] col_b;
    logic       frame_sync;

    led_matrix_scanner #(
        .TICK_DIV    (TD),
        .BLANK_TICKS (BT)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .reds       (reds),
        .greens     (greens),
        .blues      (blues),
        .row_sel    (row_sel),
        .col_r      (col_r),
        .col_g      (col_g),
        .col_b      (col_b),
        .frame_sync (frame_sync)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    logic [3:0]  p_r [64];
    logic [3:0]  p_g [64];
    logic [3:0]  p_b [64];
    logic [3:0]  s_r [64];
    logic [3:0]  s_g [64];
    logic [3:0]  s_b [64];
    logic [32:0] sb_q [$];
    int          t = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          test_id = 0;
    bit          done = 1'b0;
    bit          drained = 1'b0;

    function automatic logic [32:0] ref_out(input int tt);
        logic       fs;
        logic [7:0] rs, cr, cg, cb;
        int         ph, p, row, q, lvl;
        fs = 1'b0;
        rs = '0;
        cr = '0;
        cg = '0;
        cb = '0;
        ph = tt % PERIOD;
        if (ph == 0) begin
            fs = 1'b1;
        end else begin
            p   = ph - 1;
            row = p / ROWLEN;
            q   = p % ROWLEN;
            if (q >= BT * TD) begin
                lvl = (q - BT * TD) / TD;
                rs[row] = 1'b1;
                for (int c = 0; c < 8; c++) begin
                    cr[c] = int'(s_r[row*8+c]) > lvl;
                    cg[c] = int'(s_g[row*8+c]) > lvl;
                    cb[c] = int'(s_b[row*8+c]) > lvl;
                end
            end
        end
        return {fs, rs, cr, cg, cb};
    endfunction

    task automatic step(input logic rstv);
        @(posedge CLK100MHZ);
        #1;
        for (int i = 0; i < 64; i++) begin
            reds[i]   = p_r[i];
            greens[i] = p_g[i];
            blues[i]  = p_b[i];
        end
        CPU_RESETN = rstv;
        if (!rstv) begin
            sb_q.push_back('0);
            t = 0;
            for (int i = 0; i < 64; i++) begin
                s_r[i] = '0;
                s_g[i] = '0;
                s_b[i] = '0;
            end
        end else begin
            sb_q.push_back(ref_out(t));
            if (t % PERIOD == 0) begin
                for (int i = 0; i < 64; i++) begin
                    s_r[i] = p_r[i];
                    s_g[i] = p_g[i];
                    s_b[i] = p_b[i];
                end
            end
            t++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1);
    endtask

    task automatic restart();
        repeat (2) step(1'b0);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 64; i++) begin
            p_r[i] = '0;
            p_g[i] = '0;
            p_b[i] = '0;
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 64; i++) begin
            p_r[i] = 4'($urandom);
            p_g[i] = 4'($urandom);
            p_b[i] = 4'($urandom);
        end
    endtask

    always @(negedge CLK100MHZ) begin
        logic [32:0] e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {frame_sync, row_sel, col_r, col_g, col_b};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL test%0d outputs @%0t: got fs=%b row=%h r=%h g=%h b=%h want fs=%b row=%h r=%h g=%h b=%h",
                         test_id, $time, a[32], a[31:24], a[23:16], a[15:8], a[7:0],
                         e[32], e[31:24], e[23:16], e[15:8], e[7:0]);
            end
        end else if (done && !drained) begin
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got %0d left want 0", sb_q.size());
            end
            drained = 1'b1;
        end
    end

    initial begin
        clear_frame();
        rand_frame();
        test_id = 1;
        repeat (5) step(1'b0);
        run(2 * PERIOD + 2);

        test_id = 2;
        clear_frame();
        p_r[0] = 4'hf;
        restart();
        run(PERIOD + 2);

        test_id = 3;
        clear_frame();
        p_b[63] = 4'h1;
        restart();
        run(PERIOD + 2);

        test_id = 4;
        clear_frame();
        p_r[9] = 4'hf;
        p_g[9] = 4'hf;
        p_b[9] = 4'hf;
        p_r[10] = 4'h0;
        restart();
        run(PERIOD + 2);

        test_id = 5;
        clear_frame();
        p_r[0] = 4'hf;
        restart();
        while (t < 1 + 3 * ROWLEN + BT * TD + 5) step(1'b1);
        p_r[0] = 4'h0;
        p_r[8] = 4'h8;
        while (t < 2 * PERIOD + 2) step(1'b1);

        test_id = 6;
        rand_frame();
        restart();
        while (t < 1 + 5 * ROWLEN + BT * TD + 7) step(1'b1);
        repeat (3) step(1'b0);
        run(PERIOD + 2);

        test_id = 7;
        rand_frame();
        for (int k = 0; k < 5 * PERIOD; k++) begin
            if ($urandom_range(0, 149) == 0) rand_frame();
            step(1'b1);
        end

        repeat (3) @(posedge CLK100MHZ);
        done = 1'b1;
        for (int k = 0; k < 20 && !drained; k++) @(posedge CLK100MHZ);
        if (!drained) begin
            $display("FAIL monitor: got no drain check want one");
            $fatal(1, "monitor stalled");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
